gfx_rop: RTL and testbench

- Raster-output stage directly downstream of gfx_frag; it consumes shaded fragments (linear pixel coordinate + rgb24 colour).
- Writes each fragment into the back framebuffer through the 16-bit memory master port.
- After the write completes, it reports the pixel to gfx_masks via a one-cycle mask-assert strobe, so scanout/clear know the pixel was painted this frame.

---
 rtl/gfx_defs.sv | 51 +++++
 rtl/gfx_rop.sv | 130 +++++++++++++
 tb/tb_gfx_rop.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfx_defs.sv
// Shared types, framebuffer constants and pixel-packing helpers for the gfx pipeline.
package gfx_defs;

    localparam int COORD_W = 19;   // 640x480 = 307200 pixels
    localparam int MEM_AW  = 26;   // halfword address width
    localparam int MEM_DW  = 16;   // memory data width

    localparam logic [MEM_AW-1:0] BUF0_BASE = 26'h0000000;
    localparam logic [MEM_AW-1:0] BUF1_BASE = 26'h0100000;

    typedef logic [COORD_W-1:0] linear_coord;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24;

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI
    } rop_state;

    // One halfword write: where it goes and what it carries.
    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] data;
    } rop_word;

    // Low halfword of a 32-bit pixel slot: {G,B} at base + 2*coord (wraps mod 2^26).
    function automatic rop_word rop_lo_word(input logic [MEM_AW-1:0] base,
                                            input logic [MEM_AW-1:0] coord,
                                            input rgb24              color);
        rop_word w;
        w.addr = base + (coord << 1);
        w.data = {color.g, color.b};
        return w;
    endfunction

    // High halfword of a 32-bit pixel slot: {8'h00,R} at the next halfword address.
    function automatic rop_word rop_hi_word(input logic [MEM_AW-1:0] base,
                                            input logic [MEM_AW-1:0] coord,
                                            input rgb24              color);
        rop_word w;
        w.addr = base + (coord << 1) + 26'd1;
        w.data = {8'h00, color.r};
        return w;
    endfunction

endpackage

// File: rtl/gfx_rop.sv
// Raster-output stage: writes each shaded fragment into the back framebuffer as
// two halfwords (lo then hi) and strobes its coordinate to gfx_masks when done.
module gfx_rop #(
    parameter int                COORD_W   = gfx_defs::COORD_W,
    parameter logic [25:0]       BUF0_BASE = gfx_defs::BUF0_BASE,
    parameter logic [25:0]       BUF1_BASE = gfx_defs::BUF1_BASE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_addr,
    input  logic [23:0]        in_color,
    input  logic               back_sel,
    input  logic               hold,
    output logic [25:0]        mem_address,
    output logic               mem_write,
    output logic [15:0]        mem_writedata,
    input  logic               mem_waitrequest,
    output logic [COORD_W-1:0] rop_mask_addr,
    output logic               rop_mask_assert,
    output logic               busy
);
    import gfx_defs::*;

    rop_state           r_state;
    rop_state           w_next_state;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_lo_done;
    logic               w_hi_done;
    rop_word            w_lo_in;
    rop_word            w_hi_latched;

    logic [COORD_W-1:0] r_coord;
    rgb24               r_color;
    logic [25:0]        r_base;
    logic [25:0]        r_mem_address;
    logic [15:0]        r_mem_writedata;
    logic               r_mem_write;
    logic               r_mask_assert;
    logic [COORD_W-1:0] r_mask_addr;

    // Low word comes straight from the inputs (registered at accept); high word
    // comes from the latched fragment so later back_sel changes cannot leak in.
    assign w_lo_in      = rop_lo_word(back_sel ? BUF1_BASE : BUF0_BASE, 26'(in_addr), rgb24'(in_color));
    assign w_hi_latched = rop_hi_word(r_base, 26'(r_coord), r_color);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values, independent of block ordering.
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; ready is combinational on hold and waitrequest.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_lo_done    = (r_state == WR_LO) && !mem_waitrequest;
        w_hi_done    = (r_state == WR_HI) && !mem_waitrequest;
        case (r_state)
            IDLE: begin
                w_in_ready = !hold;
                if (in_valid && w_in_ready) w_next_state = WR_LO;
            end
            WR_LO: begin
                if (!mem_waitrequest) w_next_state = WR_HI;
            end
            WR_HI: begin
                if (!mem_waitrequest) begin
                    w_in_ready   = !hold;
                    w_next_state = (in_valid && w_in_ready) ? WR_LO : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        w_accept = in_valid && w_in_ready;
    end

    // Fragment latch, Avalon master registers and the mask strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is plain control/datapath state (no memory
            // arrays), so all of it is reset to give defined outputs out of reset.
            r_coord         <= '0;
            r_color         <= '0;
            r_base          <= '0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_mem_write     <= 1'b0;
            r_mask_assert   <= 1'b0;
            r_mask_addr     <= '0;
        end else begin
            r_mask_assert <= 1'b0;
            if (w_hi_done) begin
                r_mask_assert <= 1'b1;
                r_mask_addr   <= r_coord;
            end
            if (w_accept) begin
                r_coord         <= in_addr;
                r_color         <= rgb24'(in_color);
                r_base          <= back_sel ? BUF1_BASE : BUF0_BASE;
                r_mem_write     <= 1'b1;
                r_mem_address   <= w_lo_in.addr;
                r_mem_writedata <= w_lo_in.data;
            end else if (w_lo_done) begin
                r_mem_address   <= w_hi_latched.addr;
                r_mem_writedata <= w_hi_latched.data;
            end else if (w_hi_done) begin
                r_mem_write     <= 1'b0;
            end
        end
    end

    assign in_ready        = w_in_ready;
    assign mem_address     = r_mem_address;
    assign mem_writedata   = r_mem_writedata;
    assign mem_write       = r_mem_write;
    assign rop_mask_assert = r_mask_assert;
    assign rop_mask_addr   = r_mask_addr;
    assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_gfx_rop.sv
// Self-checking bench for gfx_rop: table-driven pixel vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_gfx_rop;

    localparam int CW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_addr = '0;
    logic [23:0]   in_color = '0;
    logic          back_sel = 1'b0;
    logic          hold = 1'b0;
    logic [25:0]   mem_address;
    logic          mem_write;
    logic [15:0]   mem_writedata;
    logic          mem_waitrequest = 1'b0;
    logic [CW-1:0] rop_mask_addr;
    logic          rop_mask_assert;
    logic          busy;

    always #5 clk = ~clk;

    gfx_rop #(.COORD_W(CW), .BUF0_BASE(26'h0000000), .BUF1_BASE(26'h0100000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_addr         (in_addr),
        .in_color        (in_color),
        .back_sel        (back_sel),
        .hold            (hold),
        .mem_address     (mem_address),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .rop_mask_addr   (rop_mask_addr),
        .rop_mask_assert (rop_mask_assert),
        .busy            (busy)
    );

    typedef struct {
        logic [25:0]   a;
        logic [15:0]   d;
        bit            hi;
        logic [CW-1:0] coord;
    } exp_t;

    typedef struct {
        logic [25:0] a;
        logic [15:0] d;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [CW-1:0] addr;
        logic [23:0]   color;
        logic          sel;
        logic [25:0]   lo_a;
        logic [15:0]   lo_d;
        logic [25:0]   hi_a;
        logic [15:0]   hi_d;
    } vec_t;

    exp_t          exp_q[$];
    obs_t          obs_q[$];
    vec_t          vecs[4];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            n_acc = 0;
    int            n_wr = 0;
    int            n_stall = 0;
    int            n_mask = 0;
    int            pend;
    exp_t          e;
    bit            mask_due = 1'b0;
    logic [CW-1:0] mask_exp_addr = '0;
    bit            last_accept = 1'b0;
    bit            prev_stall = 1'b0;
    logic [25:0]   prev_a = '0;
    logic [15:0]   prev_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a pixel is two halfword writes into a 32-bit slot of the selected buffer.
    function automatic logic [25:0] model_lo_addr(input logic [CW-1:0] a, input logic s);
        logic [25:0] base;
        base = s ? 26'h0100000 : 26'h0000000;
        return base + 26'(a) * 26'd2;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            mask_due    = 1'b0;
            prev_stall  = 1'b0;
            last_accept = 1'b0;
        end else begin
            pend = exp_q.size();
            if (prev_stall) begin
                check("stall_write_stable", 32'(mem_write), 32'd1);
                check("stall_addr_stable", 32'(mem_address), 32'(prev_a));
                check("stall_data_stable", 32'(mem_writedata), 32'(prev_d));
            end
            check("busy", 32'(busy), 32'(pend > 0));
            check("mem_write_level", 32'(mem_write), 32'(pend > 0));
            check("in_ready", 32'(in_ready),
                  32'(!hold && (pend == 0 || (pend == 1 && !mem_waitrequest))));
            check("mask_assert", 32'(rop_mask_assert), 32'(mask_due));
            if (mask_due && rop_mask_assert)
                check("mask_addr", 32'(rop_mask_addr), 32'(mask_exp_addr));
            if (rop_mask_assert) n_mask++;
            mask_due = 1'b0;
            if (mem_write && !mem_waitrequest) begin
                n_wr++;
                obs_q.push_back('{mem_address, mem_writedata, cyc});
                if (pend > 0) begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(mem_address), 32'(e.a));
                    check("write_data", 32'(mem_writedata), 32'(e.d));
                    if (e.hi) begin
                        mask_due      = 1'b1;
                        mask_exp_addr = e.coord;
                    end
                end
            end
            prev_stall = mem_write && mem_waitrequest;
            prev_a     = mem_address;
            prev_d     = mem_writedata;
            if (mem_write && mem_waitrequest) n_stall++;
            last_accept = in_valid && in_ready;
            if (last_accept) begin
                n_acc++;
                exp_q.push_back('{model_lo_addr(in_addr, back_sel), in_color[15:0], 1'b0, in_addr});
                exp_q.push_back('{model_lo_addr(in_addr, back_sel) + 26'd1,
                                  {8'h00, in_color[23:16]}, 1'b1, in_addr});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one fragment and return just after the edge that accepts it.
    task automatic send(input logic [CW-1:0] a, input logic [23:0] c, input logic s);
        in_addr  = a;
        in_color = c;
        back_sel = s;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("send_accepted", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Wait until every expected write and mask strobe has been seen.
    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !mask_due && !busy) break;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    int m0, a0, w0, s0, idx;
    bit acc;

    initial begin
        vecs[0] = '{19'd5,      24'h112233, 1'b0, 26'h000000A, 16'h2233, 26'h000000B, 16'h0011};
        vecs[1] = '{19'd0,      24'hABCDEF, 1'b1, 26'h0100000, 16'hCDEF, 26'h0100001, 16'h00AB};
        vecs[2] = '{19'd307199, 24'hFF0080, 1'b0, 26'h0095FFE, 16'h0080, 26'h0095FFF, 16'h00FF};
        vecs[3] = '{19'h7FFFF,  24'h010203, 1'b1, 26'h01FFFFE, 16'h0203, 26'h01FFFFF, 16'h0001};

        // Reset values.
        #12;
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_writedata", 32'(mem_writedata), 32'd0);
        check("rst_mask_assert", 32'(rop_mask_assert), 32'd0);
        check("rst_mask_addr", 32'(rop_mask_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Table: single pixels with no stalls, lo and hi on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            obs_q.delete();
            m0 = n_mask;
            send(vecs[i].addr, vecs[i].color, vecs[i].sel);
            wait_idle();
            check("vec_write_count", 32'(obs_q.size()), 32'd2);
            check("vec_mask_count", 32'(n_mask - m0), 32'd1);
            if (obs_q.size() >= 2) begin
                check("vec_lo_addr", 32'(obs_q[0].a), 32'(vecs[i].lo_a));
                check("vec_lo_data", 32'(obs_q[0].d), 32'(vecs[i].lo_d));
                check("vec_hi_addr", 32'(obs_q[1].a), 32'(vecs[i].hi_a));
                check("vec_hi_data", 32'(obs_q[1].d), 32'(vecs[i].hi_d));
                check("vec_consecutive", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'd1);
            end
        end

        // Waitrequest stalls: 3 cycles on lo, 2 on hi.
        obs_q.delete();
        m0 = n_mask;
        s0 = n_stall;
        mem_waitrequest = 1'b1;
        send(19'd77, 24'h5A6B7C, 1'b0);
        repeat (2) tick();
        @(posedge clk);
        #1;
        mem_waitrequest = 1'b0;
        tick();
        mem_waitrequest = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        mem_waitrequest = 1'b0;
        wait_idle();
        check("stall_cycles", 32'(n_stall - s0), 32'd5);
        check("stall_write_count", 32'(obs_q.size()), 32'd2);
        check("stall_mask_count", 32'(n_mask - m0), 32'd1);

        // Back-to-back stream of 4 fragments: 8 writes on 8 consecutive cycles.
        obs_q.delete();
        m0 = n_mask;
        idx = 0;
        in_addr  = 19'd100;
        in_color = 24'h102030;
        back_sel = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && idx < 4; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    in_addr  = CW'(100 + idx * 7);
                    in_color = 24'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        wait_idle();
        check("b2b_write_count", 32'(obs_q.size()), 32'd8);
        check("b2b_mask_count", 32'(n_mask - m0), 32'd4);
        if (obs_q.size() >= 8)
            for (int i = 1; i < 8; i++)
                check("b2b_cycle_gap", 32'(obs_q[i].cyc - obs_q[0].cyc), 32'(i));

        // back_sel is latched at accept; toggling it mid-pixel has no effect.
        obs_q.delete();
        send(19'd0, 24'h778899, 1'b1);
        back_sel = 1'b0;
        wait_idle();
        check("sel_write_count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            check("sel_lo_addr", 32'(obs_q[0].a), 32'h0100000);
            check("sel_hi_addr", 32'(obs_q[1].a), 32'h0100001);
        end

        // hold in WR_LO: current pixel completes, next one waits for hold to drop.
        obs_q.delete();
        a0 = n_acc;
        send(19'd10, 24'hC0FFEE, 1'b0);
        hold     = 1'b1;
        in_addr  = 19'd11;
        in_color = 24'h0D0E0F;
        in_valid = 1'b1;
        repeat (4) tick();
        check("hold_blocks_accept", 32'(n_acc - a0), 32'd1);
        check("hold_pixel_done", 32'(obs_q.size()), 32'd2);
        hold = 1'b0;
        send(19'd11, 24'h0D0E0F, 1'b0);
        wait_idle();
        check("hold_total_accepts", 32'(n_acc - a0), 32'd2);
        check("hold_total_writes", 32'(obs_q.size()), 32'd4);

        // Async reset in WR_HI while stalled: pixel abandoned, no mask strobe.
        obs_q.delete();
        m0 = n_mask;
        send(19'd33, 24'h445566, 1'b0);
        tick();
        mem_waitrequest = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_write", 32'(mem_write), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_mask", 32'(rop_mask_assert), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        mem_waitrequest = 1'b0;
        repeat (3) tick();
        check("arst_no_mask", 32'(n_mask - m0), 32'd0);
        check("arst_only_lo_written", 32'(obs_q.size()), 32'd1);
        obs_q.delete();
        send(19'd7, 24'h0A0B0C, 1'b1);
        wait_idle();
        check("post_rst_write_count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            check("post_rst_lo_addr", 32'(obs_q[0].a), 32'h010000E);
            check("post_rst_lo_data", 32'(obs_q[0].d), 32'h0B0C);
            check("post_rst_hi_addr", 32'(obs_q[1].a), 32'h010000F);
            check("post_rst_hi_data", 32'(obs_q[1].d), 32'h000A);
        end

        // Randomized traffic with stalls and hold against the scoreboard.
        a0 = n_acc;
        w0 = n_wr;
        for (int c = 0; c < 400; c++) begin
            tick();
            mem_waitrequest = ($urandom_range(0, 99) < 30);
            hold            = ($urandom_range(0, 99) < 15);
            if (!in_valid || last_accept) begin
                in_valid = ($urandom_range(0, 99) < 70);
                in_addr  = CW'($urandom_range(0, 307199));
                in_color = 24'($urandom);
                back_sel = 1'($urandom_range(0, 1));
            end
        end
        in_valid        = 1'b0;
        hold            = 1'b0;
        mem_waitrequest = 1'b0;
        wait_idle();
        check("rand_writes_per_accept", 32'(n_wr - w0), 32'(2 * (n_acc - a0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
